ram_march_bist: RTL

- Initiator-side controller for the 64x8 single-port RAM (data/addr/we/clk → q).
- Drives the RAM's write/address/enable inputs and checks its read data `q`, running a March-style self-test over every address.
- Reports pass/fail, plus the first failing address and the data read there.
- Sits beside the RAM behind a test mux; it is the hardware replacement for a hand-written stimulus sequence.

---
 rtl/ram_bist_pkg.sv | 47 ++++
 rtl/ram_march_bist_if.sv | 13 +
 rtl/bist_addr_gen.sv | 24 ++
 rtl/ram_march_bist.sv | 123 ++++++++++++
 4 files changed

// File: rtl/ram_bist_pkg.sv
// Shared types for the RAM March BIST: FSM states and per-element descriptors.
package ram_bist_pkg;

    localparam int BIST_DATA_W = 8;
    localparam int BIST_ADDR_W = 6;

    typedef enum logic [2:0] {IDLE, W_UP, RW_UP, RW_DN, R_DN, DONE} state_t;

    typedef struct packed {
        logic up;       // address direction
        logic exp_inv;  // compare against ~P
        logic wr_en;    // element writes after its compare
        logic wr_inv;   // written word is ~P
    } elem_t;

    localparam elem_t E_NONE  = '{up: 1'b1, exp_inv: 1'b0, wr_en: 1'b0, wr_inv: 1'b0};
    localparam elem_t E_W_UP  = '{up: 1'b1, exp_inv: 1'b0, wr_en: 1'b1, wr_inv: 1'b0};
    localparam elem_t E_RW_UP = '{up: 1'b1, exp_inv: 1'b0, wr_en: 1'b1, wr_inv: 1'b1};
    localparam elem_t E_RW_DN = '{up: 1'b0, exp_inv: 1'b1, wr_en: 1'b1, wr_inv: 1'b0};
    localparam elem_t E_R_DN  = '{up: 1'b0, exp_inv: 1'b0, wr_en: 1'b0, wr_inv: 1'b0};

    function automatic elem_t elem_of(state_t s);
        elem_t e;
        e = E_NONE;
        case (s)
            W_UP:    e = E_W_UP;
            RW_UP:   e = E_RW_UP;
            RW_DN:   e = E_RW_DN;
            R_DN:    e = E_R_DN;
            default: e = E_NONE;
        endcase
        return e;
    endfunction

    function automatic state_t next_elem(state_t s);
        state_t n;
        n = DONE;
        case (s)
            W_UP:    n = RW_UP;
            RW_UP:   n = RW_DN;
            RW_DN:   n = R_DN;
            default: n = DONE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ram_march_bist_if.sv
// Single-port RAM bus as seen by the BIST (master) and the RAM (slave).
interface ram_march_bist_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
);
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] q;

    modport master (output data, output addr, output we, input q);
    modport slave  (input data, input addr, input we, output q);
endinterface

// File: rtl/bist_addr_gen.sv
// Loadable up/down address counter; last flags the terminal address for the direction.
module bist_addr_gen #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              step,
    input  logic              up,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    assign last = up ? (addr == '1) : (addr == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            addr <= '0;
        else if (load)
            addr <= load_val;
        else if (step)
            addr <= up ? addr + 1'b1 : addr - 1'b1;
    end
endmodule

// File: rtl/ram_march_bist.sv
// March BIST controller: W_UP(P), RW_UP(rP,w~P), RW_DN(r~P,wP), R_DN(rP) over the whole RAM.
module ram_march_bist
    import ram_bist_pkg::*;
#(
    parameter int DATA_W = BIST_DATA_W,
    parameter int ADDR_W = BIST_ADDR_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] pattern,
    ram_march_bist_if.master  ram,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
);
    localparam int CNT_W = 2;

    state_t            state, nstate;
    elem_t             el;
    logic [DATA_W-1:0] pat, wdata, expect_w;
    logic              we, clean;
    logic [CNT_W-1:0]  rcnt;
    logic [ADDR_W-1:0] addr, load_val;
    logic              last, accept, cmp, adv, miss, load, step;

    assign ram.data = wdata;
    assign ram.addr = addr;
    assign ram.we   = we;

    always_comb begin
        el       = elem_of(state);
        nstate   = next_elem(state);
        accept   = start && (state == IDLE || state == DONE);
        // rcnt counts the read slot; reaching RD_LAT marks the compare/write cycle
        cmp      = (state inside {RW_UP, RW_DN, R_DN}) && (rcnt == CNT_W'(RD_LAT));
        adv      = (state == W_UP) || cmp;
        expect_w = el.exp_inv ? ~pat : pat;
        miss     = cmp && (ram.q != expect_w);
        step     = adv && !last;
        load     = accept || (adv && last);
        load_val = (accept || elem_of(nstate).up) ? '0 : '1;
    end

    bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .step     (step),
        .up       (el.up),
        .addr     (addr),
        .last     (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pat       <= '0;
            wdata     <= '0;
            we        <= 1'b0;
            rcnt      <= '0;
            clean     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
        end else if (accept) begin
            state     <= W_UP;
            pat       <= pattern;
            wdata     <= pattern;
            we        <= 1'b1;
            rcnt      <= '0;
            clean     <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            case (state)
                W_UP: begin
                    if (last) begin
                        state <= nstate;
                        we    <= 1'b0;
                        rcnt  <= '0;
                    end
                end
                RW_UP, RW_DN, R_DN: begin
                    if (!cmp) begin
                        rcnt <= rcnt + 1'b1;
                        if (rcnt == CNT_W'(RD_LAT - 1)) begin
                            we    <= el.wr_en;
                            wdata <= el.wr_inv ? ~pat : pat;
                        end
                    end else begin
                        rcnt <= '0;
                        we   <= 1'b0;
                        // only the first miscompare is recorded
                        if (miss && clean) begin
                            clean     <= 1'b0;
                            fail_addr <= addr;
                            fail_data <= ram.q;
                        end
                        if (last) begin
                            state <= nstate;
                            if (nstate == DONE) begin
                                busy <= 1'b0;
                                done <= 1'b1;
                                pass <= clean && !miss;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
